// File: rtl/fb_stream_reader_pkg.sv
// rtl/fb_stream_reader_pkg.sv - shared constants, state encoding and stream entry layout
package fb_stream_reader_pkg;

    localparam int DEF_WIDTH = 11;
    localparam int DEF_H_RES = 320;
    localparam int DEF_V_RES = 240;
    localparam int META_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Stream entry, MSB first: {sof, eol, data[width-1:0]}
    function automatic int entry_w(input int width);
        return width + META_W;
    endfunction

    function automatic int sof_bit(input int width);
        return width + 1;
    endfunction

    function automatic int eol_bit(input int width);
        return width;
    endfunction

endpackage

// File: rtl/fb_skid_fifo.sv
// rtl/fb_skid_fifo.sv - 2-entry register FIFO with occupancy count and synchronous flush
module fb_skid_fifo #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         wr_ptr;
    logic         rd_ptr;

    assign head = rd_ptr ? mem1 : mem0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    mem1 <= push_data;
                end else begin
                    mem0 <= push_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fb_stream_reader.sv
// rtl/fb_stream_reader.sv - frame-buffer read master: raster BRAM reads to a valid/ready pixel stream
module fb_stream_reader
    import fb_stream_reader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int DEPTH = H_RES * V_RES
) (
    input  logic                     rclk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     rd,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    input  logic [WIDTH-1:0]         rd_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_sof,
    output logic                     m_eol
);

    localparam int AW      = $clog2(DEPTH);
    localparam int XW      = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW      = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int EW      = entry_w(WIDTH);
    localparam int SOF_BIT = sof_bit(WIDTH);
    localparam int EOL_BIT = eol_bit(WIDTH);

    state_t         state;
    state_t         state_nxt;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           inflight;
    logic [1:0]     meta_q;
    logic [1:0]     fifo_count;
    logic [EW-1:0]  head;
    logic [2:0]     occupancy;
    logic           pop;
    logic           push;
    logic           flush;
    logic           accept;
    logic           line_end;
    logic           last_issue;
    logic           drained;

    assign busy       = (state != ST_IDLE);
    assign accept     = (state == ST_IDLE) && start && !abort;
    assign flush      = abort && busy;
    assign pop        = m_valid && m_ready;
    // A capture that lands in the abort cycle belongs to the discarded frame.
    assign push       = inflight && !flush;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign line_end   = (x == XW'(H_RES - 1));
    assign last_issue = line_end && (y == YW'(V_RES - 1));
    assign drained    = !inflight && (fifo_count == 2'd0);

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (occupancy < 3'd2) begin
                    rd = 1'b1;
                    if (last_issue) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (drained) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rd_addr  <= '0;
            x        <= '0;
            y        <= '0;
            inflight <= 1'b0;
            meta_q   <= 2'b00;
        end else begin
            state    <= state_nxt;
            inflight <= rd;
            if (rd) begin
                meta_q <= {(x == '0) && (y == '0), line_end};
            end
            if (accept) begin
                rd_addr <= '0;
                x       <= '0;
                y       <= '0;
            end else if (rd && !last_issue) begin
                // The address parks on DEPTH-1 after the final issue instead of wrapping.
                rd_addr <= rd_addr + AW'(1);
                if (line_end) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    fb_skid_fifo #(
        .W(EW)
    ) u_out_fifo (
        .clk       (rclk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ({meta_q, rd_data}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = m_valid ? head[WIDTH-1:0] : '0;
    assign m_sof   = m_valid && head[SOF_BIT];
    assign m_eol   = m_valid && head[EOL_BIT];

endmodule

// File: doc/fb_stream_reader.md
Name: fb_stream_reader

Overview:
- Read-side master for the dual-clock frame-buffer BRAM. Lives in the read clock domain.
- On a start pulse it reads one full frame, raster order, address 0 to H_RES*V_RES-1.
- It drives the BRAM read strobe and address, absorbs the 1-cycle BRAM read latency, and emits pixels on a valid/ready stream with start-of-frame and end-of-line markers.
- Feeds the downstream image-processing / video-out pipeline; tolerates arbitrary backpressure without dropping or duplicating pixels.

Parameters:
- WIDTH, 11, pixel width; matches the frame-buffer word.
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- DEPTH, H_RES*V_RES, frame-buffer depth; the address width is $clog2(DEPTH).

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame read when idle.
- abort  in  1  synchronous; terminates the current frame.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse after the last pixel handshake.
- rd  out  1  BRAM read enable.
- rd_addr  out  $clog2(DEPTH)  BRAM read address.
- rd_data  in  WIDTH  BRAM output; valid the cycle after rd.
- m_valid  out  1  stream pixel valid.
- m_ready  in  1  downstream accept.
- m_data  out  WIDTH  pixel.
- m_sof  out  1  qualifies pixel (0,0).
- m_eol  out  1  qualifies the last pixel of each line (x==H_RES-1).

Behaviour:
- Reset: the following are 0 and the state is IDLE.
  - busy, done, rd, rd_addr, m_valid, m_data, m_sof, m_eol.
  - All counters and the FIFO.
- States:
  - IDLE: start→READ. busy rises in the cycle after start.
  - READ: issue reads until rd_addr has issued DEPTH-1, then →DRAIN.
  - DRAIN: wait until the inflight read and the FIFO are both empty, then pulse done and →IDLE.
- Read issue: rd=1 in cycle t only if state==READ and (fifo_count + inflight − pop) < 2.
  - pop = m_valid & m_ready.
  - inflight = rd registered one cycle.
  - rd_addr increments after each issued read and holds when rd=0.
- Capture: if rd was high in cycle t, rd_data is written to a 2-entry output FIFO at the end of t+1. The FIFO never overflows, because of the issue rule.
- Stream: m_valid = FIFO not empty. m_data, m_sof and m_eol come from the FIFO head.
- m_sof/m_eol are derived from an issue-side x/y counter and stored alongside the data (WIDTH+2 bit entries).
- Once m_valid is high, it and the head entry stay stable until a handshake.
- Latency: start at cycle 0 → rd with address 0 at cycle 1 → m_valid at cycle 3.
- Throughput: with m_ready held high, 1 pixel/cycle sustained. The last pixel handshake happens at cycle DEPTH+2, and done pulses at cycle DEPTH+3.
- Counters:
  - x wraps at H_RES-1 and increments y.
  - y reaching V_RES-1 with x at H_RES-1 marks the last issue.
  - No address wrap inside a frame; rd_addr returns to 0 on the next start.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: abort wins; no frame starts.
- abort in READ/DRAIN: in the next cycle the following happen, with no done pulse:
  - rd=0 and the FIFO is flushed (m_valid=0);
  - the inflight return is discarded;
  - state goes to IDLE and busy falls.
- rst_n low mid-frame: everything clears immediately, as at reset. The first start after reset begins at address 0.
- m_ready high while m_valid is low has no effect.

Decomposition:
- Shared package holds:
  - default H_RES/V_RES/WIDTH constants;
  - a state enum (IDLE, READ, DRAIN);
  - the stream entry bit layout {sof, eol, data}.
- One natural sub-module: fb_skid_fifo, a 2-entry register FIFO with count output and synchronous flush, instantiated for the output buffer.

Test Plan:
- H_RES=4, V_RES=3, m_ready=1, start at cycle 0:
  - rd at cycles 1..12 with addresses 0..11;
  - m_data equals the BRAM contents in order;
  - m_sof only on the first pixel; m_eol on pixels 3, 7, 11;
  - done at cycle 15.
- Default parameters, randomised m_ready (50%): exactly 76800 handshakes in address order, no duplicates or skips. m_valid/m_data are stable while m_ready=0, and rd never leaves more than 2 outstanding plus buffered.
- m_ready held low for 20 cycles mid-line: at most 2 reads are issued, then rd=0. On release, the stream resumes with the next sequential pixel.
- start pulsed again at cycle 5 of a frame: ignored, the frame completes normally, and a single done pulse occurs.
- abort at pixel 5 of the 4x3 frame:
  - next cycle m_valid=0, busy=0, rd=0, no done;
  - a following start reads from address 0 with m_sof on the first pixel.
- rst_n asserted mid-frame: all outputs are 0 immediately. After release, no stream activity until start.
